ccip_c0rd_arbiter: RTL

Round-robin arbiter that shares the CCI-P c0 Tx (memory read request) channel among `NUM_REQ` AFU-side requesters and routes the matching c0 Rx read responses back to the originator. It sits between the AFU engines and the registered CCI-P boundary, on the AFU side of the T1 signals. It does three things: tags request `mdata` with the requester index, honours `c0TxAlmFull`, and limits each requester's outstanding cache lines.

---
 rtl/ccip_c0rd_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ccip_c0rd_arbiter.sv
// ccip_c0rd_arbiter
// Round-robin arbiter sharing the CCI-P c0 Tx read-request channel among NUM_REQ requesters.
// Tags request mdata with the requester index, honours c0TxAlmFull, caps outstanding lines per
// requester and steers c0 Rx read responses back to their originator.
//
// Ports:
//   pClk, pck_cp2af_softReset       clock, asynchronous active-high reset
//   req_valid/ready/addr/cl_len/mdata  per-requester read request (flattened vectors)
//   c0TxAlmFull                     shell almost-full, sampled combinationally
//   c0tx_valid/addr/cl_len/mdata    registered request towards the shell
//   c0rx_rd_valid/mdata/data        read response line from the shell
//   rsp_valid/mdata/data            registered, one-hot routed response
//   err_unexp_rsp                   sticky: response with no matching outstanding line
module ccip_c0rd_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_OUTST = 64
) (
  input  logic                    pClk,
  input  logic                    pck_cp2af_softReset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*42-1:0]   req_addr,
  input  logic [NUM_REQ*2-1:0]    req_cl_len,
  input  logic [NUM_REQ*16-1:0]   req_mdata,
  input  logic                    c0TxAlmFull,
  output logic                    c0tx_valid,
  output logic [41:0]             c0tx_addr,
  output logic [1:0]              c0tx_cl_len,
  output logic [15:0]             c0tx_mdata,
  input  logic                    c0rx_rd_valid,
  input  logic [15:0]             c0rx_mdata,
  input  logic [511:0]            c0rx_data,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [15:0]             rsp_mdata,
  output logic [511:0]            rsp_data,
  output logic                    err_unexp_rsp
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned LO_W = 16 - ID_W;

  logic [ID_W-1:0]    rrPtrQ, rrPtrD;
  logic [7:0]         outstQ [NUM_REQ];
  logic [7:0]         outstD [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] unexpHit;
  logic               grantVld;
  logic [ID_W-1:0]    grantIdx;
  logic [ID_W-1:0]    rspTag;
  logic               tagOk;
  logic [NUM_REQ-1:0] rspValidD;
  logic               errD;
  logic [41:0]        selAddr;
  logic [1:0]         selLen;
  logic [15:0]        selMdata;

  assign rspTag = c0rx_mdata[15 -: ID_W];

  // Tags beyond NUM_REQ can only exist when NUM_REQ is not a power of two.
  if (NUM_REQ == (1 << ID_W)) begin : gTagAll
    assign tagOk = 1'b1;
  end else begin : gTagRange
    assign tagOk = 32'(rspTag) < NUM_REQ;
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gReq
    logic [1:0] clLen;
    logic [8:0] needLines;
    logic       grantHere;
    logic       rspHere;
    logic [7:0] sumLines;

    assign clLen     = req_cl_len[2*gi +: 2];
    assign needLines = {1'b0, outstQ[gi]} + {7'b0, clLen} + 9'd1;
    assign eligible[gi] = req_valid[gi] && (clLen != 2'd2) && (needLines <= 9'(MAX_OUTST));

    assign grantHere = grantVld && (grantIdx == ID_W'(gi));
    assign rspHere   = c0rx_rd_valid && tagOk && (rspTag == ID_W'(gi));
    assign sumLines  = outstQ[gi] + (grantHere ? ({6'b0, clLen} + 8'd1) : 8'd0);
    // Decrement saturates at zero; a response seen at zero is flagged separately.
    assign outstD[gi]   = rspHere ? ((sumLines == 8'd0) ? 8'd0 : sumLines - 8'd1) : sumLines;
    assign unexpHit[gi] = rspHere && (outstQ[gi] == 8'd0);
  end

  // Round-robin search starting at rrPtrQ; first eligible index wins.
  always_comb begin
    int unsigned idx;
    grantVld = 1'b0;
    grantIdx = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rrPtrQ) + k) % NUM_REQ;
      if (!grantVld && eligible[idx]) begin
        grantVld = 1'b1;
        grantIdx = ID_W'(idx);
      end
    end
    if (c0TxAlmFull) grantVld = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (grantVld) req_ready[grantIdx] = 1'b1;
  end

  always_comb begin
    rrPtrD = rrPtrQ;
    if (grantVld) rrPtrD = (32'(grantIdx) == NUM_REQ - 1) ? '0 : grantIdx + 1'b1;
  end

  assign selAddr  = req_addr[32'(grantIdx) * 42 +: 42];
  assign selLen   = req_cl_len[32'(grantIdx) * 2 +: 2];
  assign selMdata = req_mdata[32'(grantIdx) * 16 +: 16];

  always_comb begin
    rspValidD = '0;
    if (c0rx_rd_valid && tagOk) rspValidD[rspTag] = 1'b1;
  end

  assign errD = err_unexp_rsp | (c0rx_rd_valid & ~tagOk) | (|unexpHit);

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      rrPtrQ <= '0;
      for (int i = 0; i < NUM_REQ; i++) outstQ[i] <= '0;
      c0tx_valid    <= 1'b0;
      c0tx_addr     <= '0;
      c0tx_cl_len   <= '0;
      c0tx_mdata    <= '0;
      rsp_valid     <= '0;
      rsp_mdata     <= '0;
      rsp_data      <= '0;
      err_unexp_rsp <= 1'b0;
    end else begin
      rrPtrQ <= rrPtrD;
      for (int i = 0; i < NUM_REQ; i++) outstQ[i] <= outstD[i];
      c0tx_valid <= grantVld;
      if (grantVld) begin
        c0tx_addr   <= selAddr;
        c0tx_cl_len <= selLen;
        c0tx_mdata  <= {grantIdx, selMdata[LO_W-1:0]};
      end
      rsp_valid <= rspValidD;
      if (c0rx_rd_valid) begin
        rsp_mdata <= {{ID_W{1'b0}}, c0rx_mdata[LO_W-1:0]};
        rsp_data  <= c0rx_data;
      end
      err_unexp_rsp <= errD;
    end
  end

endmodule
